// File: rtl/div_unit_if.sv
// ---------------------------------------------------------------------------
// div_unit_if
// Handshake and data bundle between the EX stage and the radix-2 divider.
//   start_i    : EX holds a DIV/DIVU (held until the instruction leaves EX)
//   signed_i   : 1 = DIV (two's complement), 0 = DIVU
//   dividend_i : rs operand
//   divisor_i  : rt operand
//   annul_i    : flush/exception in EX, aborts the current operation
//   result_o   : {remainder (HI), quotient (LO)}
//   ready_o    : result_o valid
//   stall_o    : stall request towards the hazard unit
// Modports: master = EX stage side, slave = divider side.
// ---------------------------------------------------------------------------
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic                 start_i;
  logic                 signed_i;
  logic [WIDTH-1:0]     dividend_i;
  logic [WIDTH-1:0]     divisor_i;
  logic                 annul_i;
  logic [2*WIDTH-1:0]   result_o;
  logic                 ready_o;
  logic                 stall_o;

  modport master (
    output start_i, signed_i, dividend_i, divisor_i, annul_i,
    input  result_o, ready_o, stall_o
  );

  modport slave (
    input  start_i, signed_i, dividend_i, divisor_i, annul_i,
    output result_o, ready_o, stall_o
  );
endinterface

// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage.
// Produces {HI,LO} = {remainder, quotient} for the HI/LO register and holds
// the pipeline through stall_o while the division is in flight.
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : div_unit_if.slave (start/signed/operands/annul in,
//         result/ready/stall out)
// Signed operations divide magnitudes and fix signs up at the end:
// quotient negative when operand signs differ, remainder follows dividend.
// ---------------------------------------------------------------------------
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  // {partial remainder (WIDTH+1 bits), dividend/quotient (WIDTH bits)}
  logic [2*WIDTH:0]     part_q;
  logic [WIDTH-1:0]     dvs_q;
  logic                 sgn_q;
  logic                 dvd_neg_q;
  logic                 q_neg_q;
  // Set on accept and cleared once start_i drops, so one instruction is
  // never accepted twice.
  logic                 hold_q;
  logic [2*WIDTH-1:0]   result_q;
  logic                 ready_q;

  logic                 accept_d;
  logic                 a_neg_d;
  logic                 b_neg_d;
  logic [WIDTH-1:0]     a_abs_d;
  logic [WIDTH-1:0]     b_abs_d;
  logic [2*WIDTH:0]     shift_d;
  logic [WIDTH:0]       trial_d;
  logic [2*WIDTH:0]     step_d;
  logic [WIDTH-1:0]     quot_d;
  logic [WIDTH-1:0]     rem_d;
  logic [WIDTH-1:0]     dvd_orig_d;

  // Accept decision, operand magnitudes, one restoring step and sign fix-up.
  always_comb begin
    accept_d = (state_q == S_IDLE) && bus.start_i && !bus.annul_i && !hold_q;

    a_neg_d = bus.signed_i & bus.dividend_i[WIDTH-1];
    b_neg_d = bus.signed_i & bus.divisor_i[WIDTH-1];
    if (a_neg_d) begin
      a_abs_d = {WIDTH{1'b0}} - bus.dividend_i;
    end else begin
      a_abs_d = bus.dividend_i;
    end
    if (b_neg_d) begin
      b_abs_d = {WIDTH{1'b0}} - bus.divisor_i;
    end else begin
      b_abs_d = bus.divisor_i;
    end

    // Shift left, trial-subtract from the upper half; a clear top bit of the
    // difference means it did not go negative, so keep it and set the q bit.
    shift_d = {part_q[2*WIDTH-1:0], 1'b0};
    trial_d = shift_d[2*WIDTH:WIDTH] - {1'b0, dvs_q};
    if (!trial_d[WIDTH]) begin
      step_d = {trial_d, shift_d[WIDTH-1:1], 1'b1};
    end else begin
      step_d = shift_d;
    end

    if (q_neg_q) begin
      quot_d = {WIDTH{1'b0}} - part_q[WIDTH-1:0];
    end else begin
      quot_d = part_q[WIDTH-1:0];
    end
    if (sgn_q && dvd_neg_q) begin
      rem_d = {WIDTH{1'b0}} - part_q[2*WIDTH-1:WIDTH];
    end else begin
      rem_d = part_q[2*WIDTH-1:WIDTH];
    end

    // Divide-by-zero reports the original dividend bits; undo the magnitude.
    if (dvd_neg_q) begin
      dvd_orig_d = {WIDTH{1'b0}} - part_q[WIDTH-1:0];
    end else begin
      dvd_orig_d = part_q[WIDTH-1:0];
    end
  end

  // Divider FSM with registered result/ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= {CW{1'b0}};
      part_q    <= {(2*WIDTH+1){1'b0}};
      dvs_q     <= {WIDTH{1'b0}};
      sgn_q     <= 1'b0;
      dvd_neg_q <= 1'b0;
      q_neg_q   <= 1'b0;
      hold_q    <= 1'b0;
      result_q  <= {(2*WIDTH){1'b0}};
      ready_q   <= 1'b0;
    end else begin
      if (accept_d) begin
        hold_q <= 1'b1;
      end else if (!bus.start_i) begin
        hold_q <= 1'b0;
      end else begin
        hold_q <= hold_q;
      end

      case (state_q)
        S_IDLE: begin
          ready_q <= 1'b0;
          if (accept_d) begin
            part_q    <= {{(WIDTH+1){1'b0}}, a_abs_d};
            dvs_q     <= b_abs_d;
            sgn_q     <= bus.signed_i;
            dvd_neg_q <= a_neg_d;
            q_neg_q   <= a_neg_d ^ b_neg_d;
            cnt_q     <= {CW{1'b0}};
            if (bus.divisor_i == {WIDTH{1'b0}}) begin
              state_q <= S_BYZERO;
            end else begin
              state_q <= S_ON;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end

        S_BYZERO: begin
          if (bus.annul_i) begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
          end else begin
            result_q <= {dvd_orig_d, {WIDTH{1'b1}}};
            ready_q  <= 1'b1;
            state_q  <= S_END;
          end
        end

        S_ON: begin
          if (bus.annul_i) begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            result_q <= {rem_d, quot_d};
            ready_q  <= 1'b1;
            state_q  <= S_END;
          end else begin
            part_q <= step_d;
            cnt_q  <= cnt_q + CW'(1);
          end
        end

        S_END: begin
          if (bus.annul_i || !bus.start_i) begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
          end else begin
            state_q <= S_END;
            ready_q <= 1'b1;
          end
        end

        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // stall_o must be combinational so the very first EX cycle is held.
  assign bus.stall_o  = accept_d || (state_q == S_BYZERO) || (state_q == S_ON);
  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// ---------------------------------------------------------------------------
// tb_div_unit
// Directed bench for div_unit: expected {HI,LO} values come from a small
// reference model, are queued when a division is launched and compared when
// ready_o rises. Latency, stall_o, annul and reset behaviour are checked too.
// ---------------------------------------------------------------------------
module tb_div_unit;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  div_unit_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int           errors = 0;
  int           checks = 0;
  logic [63:0]  sb[$];
  logic [63:0]  last_res;

  // Reference: 64-bit arithmetic avoids the INT_MIN / -1 overflow trap.
  function automatic logic [63:0] model(input logic sg, input logic [31:0] a,
                                        input logic [31:0] b);
    int     ai;
    int     bi;
    longint la;
    longint lb;
    longint lq;
    longint lr;
    logic [31:0] uq;
    logic [31:0] ur;
    if (b == 32'd0) begin
      return {a, 32'hFFFF_FFFF};
    end
    if (sg) begin
      ai = a;
      bi = b;
      la = ai;
      lb = bi;
      lq = la / lb;
      lr = la % lb;
      return {lr[31:0], lq[31:0]};
    end
    uq = a / b;
    ur = a % b;
    return {ur, uq};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Launch one division, wait for ready, check latency/stall/result, then
  // hold start one extra cycle and release it.
  task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input string tag);
    int          n;
    logic [63:0] exp;
    bus.signed_i   = sg;
    bus.dividend_i = a;
    bus.divisor_i  = b;
    bus.start_i    = 1'b1;
    sb.push_back(model(sg, a, b));
    #1;
    chk({tag, " stall_at_accept"}, 64'(bus.stall_o), 64'd1);
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      // Operands change after accept and must be ignored.
      bus.dividend_i = $urandom;
      bus.divisor_i  = $urandom;
      bus.signed_i   = ~sg;
      if (bus.ready_o === 1'b1) break;
      chk({tag, " stall_busy"}, 64'(bus.stall_o), 64'd1);
    end
    chk({tag, " latency"}, 64'(n), 64'(lat));
    exp = sb.pop_front();
    chk({tag, " result"}, bus.result_o, exp);
    last_res = exp;
    tick();
    chk({tag, " ready_held"}, 64'(bus.ready_o), 64'd1);
    chk({tag, " result_held"}, bus.result_o, exp);
    chk({tag, " stall_end"}, 64'(bus.stall_o), 64'd0);
    bus.start_i = 1'b0;
    tick();
    chk({tag, " ready_drop"}, 64'(bus.ready_o), 64'd0);
    chk({tag, " result_keep"}, bus.result_o, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen_ready;
    rst            = 1'b1;
    bus.start_i    = 1'b0;
    bus.signed_i   = 1'b0;
    bus.dividend_i = 32'd0;
    bus.divisor_i  = 32'd0;
    bus.annul_i    = 1'b0;
    last_res       = 64'd0;
    tick();
    tick();
    chk("reset result", bus.result_o, 64'd0);
    chk("reset ready", 64'(bus.ready_o), 64'd0);
    chk("reset stall", 64'(bus.stall_o), 64'd0);
    rst = 1'b0;
    tick();

    run_div(1'b0, 32'd100,        32'd7,        34, "divu_100_7");
    chk("divu_100_7 const", last_res, {32'h0000_0002, 32'h0000_000E});
    run_div(1'b1, 32'hFFFF_FFF9,  32'd2,        34, "div_m7_2");
    chk("div_m7_2 const", last_res, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_div(1'b1, 32'd7,          32'hFFFF_FFFE, 34, "div_7_m2");
    chk("div_7_m2 const", last_res, {32'h0000_0001, 32'hFFFF_FFFD});
    run_div(1'b0, 32'h1234_5678,  32'd0,        2,  "divu_by0");
    chk("divu_by0 const", last_res, {32'h1234_5678, 32'hFFFF_FFFF});
    run_div(1'b1, 32'hFFFF_FFF9,  32'd0,        2,  "div_neg_by0");
    run_div(1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 34, "div_ovf");
    chk("div_ovf const", last_res, {32'h0000_0000, 32'h8000_0000});
    run_div(1'b0, 32'hFFFF_FFFF,  32'd1,        34, "divu_max_1");

    // Annul in the middle of ON: abort, no ready, result untouched.
    bus.signed_i   = 1'b0;
    bus.dividend_i = 32'd1000;
    bus.divisor_i  = 32'd3;
    bus.start_i    = 1'b1;
    tick();
    repeat (10) tick();
    chk("annul pre_stall", 64'(bus.stall_o), 64'd1);
    bus.annul_i = 1'b1;
    tick();
    chk("annul ready", 64'(bus.ready_o), 64'd0);
    chk("annul stall", 64'(bus.stall_o), 64'd0);
    chk("annul result", bus.result_o, last_res);
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    seen_ready  = 0;
    repeat (40) begin
      tick();
      if (bus.ready_o === 1'b1) seen_ready++;
    end
    chk("annul no_ready", 64'(seen_ready), 64'd0);
    chk("annul idle_stall", 64'(bus.stall_o), 64'd0);
    run_div(1'b0, 32'd9, 32'd3, 34, "after_annul");
    chk("after_annul const", last_res, {32'h0000_0000, 32'h0000_0003});

    // Reset in the middle of ON.
    bus.signed_i   = 1'b1;
    bus.dividend_i = 32'd12345;
    bus.divisor_i  = 32'hFFFF_FFEF;
    bus.start_i    = 1'b1;
    tick();
    repeat (20) tick();
    rst         = 1'b1;
    bus.start_i = 1'b0;
    tick();
    chk("midrst result", bus.result_o, 64'd0);
    chk("midrst ready", 64'(bus.ready_o), 64'd0);
    chk("midrst stall", 64'(bus.stall_o), 64'd0);
    rst = 1'b0;
    tick();
    chk("midrst idle_ready", 64'(bus.ready_o), 64'd0);

    // Back-to-back with a single-cycle start gap.
    run_div(1'b1, 32'hFFFF_FF9C, 32'd7,      34, "b2b_first");
    run_div(1'b0, 32'hDEAD_BEEF, 32'h1234,   34, "b2b_second");
    run_div(1'b1, 32'd12345,     32'hFFFF_FFEF, 34, "b2b_third");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
